// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt-acknowledge cascade sequencer.
package pic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK1 = 2'd1,
    ST_GAP  = 2'd2,
    ST_ACK2 = 2'd3
  } state_t;

  localparam logic ROLE_MASTER = 1'b1;
  localparam logic ROLE_SLAVE  = 1'b0;

  localparam logic [2:0] LVL_SPURIOUS = 3'd7;

endpackage

// File: rtl/inta_edge_det.sv
// Detects falling and rising edges of the synchronous INTAn strobe.
module inta_edge_det (
  input  logic CLK,
  input  logic RSTn,
  input  logic INTAn,
  output logic fall,
  output logic rise
);

  logic inta_prev;

  // Previous INTAn sample; resets high so a low INTAn after reset reads as a fall only once.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) inta_prev <= 1'b1;
    else       inta_prev <= INTAn;
  end

  assign fall = ~INTAn & inta_prev;
  assign rise = INTAn & ~inta_prev;

endmodule

// File: rtl/inta_cascade_seq.sv
// Two-pulse INTA sequencer: level latch, cascade ID drive, vector enable and ISR set/clear pulses.
module inta_cascade_seq
  import pic_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       INTAn,
  input  logic       SPENn,
  input  logic       BUF,
  input  logic       MS,
  input  logic [7:0] ICW3,
  input  logic [4:0] VEC_BASE,
  input  logic       AEOI,
  input  logic       INT_REQ,
  input  logic [2:0] IRQ_LVL,
  input  logic [2:0] CAS_IN,
  output logic [2:0] CAS_OUT,
  output logic       CAS_OE,
  output logic       VEC_OE,
  output logic [7:0] VEC,
  output logic       BUFENn,
  output logic       ISR_SET,
  output logic       ISR_CLR,
  output logic [2:0] ISR_LVL,
  output logic       SPUR
);

  state_t     state;
  logic       fall;
  logic       rise;
  logic       role_live;
  logic       role_q;
  logic       aeoi_q;
  logic       set_done;
  logic       cascaded;
  logic       match_q;
  logic [2:0] lvl;

  inta_edge_det u_edge (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .INTAn (INTAn),
    .fall  (fall),
    .rise  (rise)
  );

  // In buffered mode the SP/EN pin is a transceiver enable, so MS carries the role instead.
  assign role_live = BUF ? MS : SPENn;

  assign ISR_LVL = lvl;
  assign VEC     = {VEC_BASE, lvl};
  assign BUFENn  = ~(BUF & VEC_OE);

  // Acknowledge FSM with all sequence outputs registered on the detecting edge.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      role_q   <= ROLE_MASTER;
      aeoi_q   <= 1'b0;
      set_done <= 1'b0;
      cascaded <= 1'b0;
      match_q  <= 1'b0;
      lvl      <= 3'd0;
      CAS_OUT  <= 3'd0;
      CAS_OE   <= 1'b0;
      VEC_OE   <= 1'b0;
      ISR_SET  <= 1'b0;
      ISR_CLR  <= 1'b0;
      SPUR     <= 1'b0;
    end else begin
      ISR_SET <= 1'b0;
      ISR_CLR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_ACK1;
            role_q   <= role_live;
            aeoi_q   <= AEOI;
            set_done <= 1'b0;
            cascaded <= 1'b0;
            match_q  <= 1'b0;
            if (role_live == ROLE_MASTER) begin
              if (INT_REQ) begin
                lvl      <= IRQ_LVL;
                ISR_SET  <= 1'b1;
                set_done <= 1'b1;
                SPUR     <= 1'b0;
                if (ICW3[IRQ_LVL]) begin
                  CAS_OUT  <= IRQ_LVL;
                  CAS_OE   <= 1'b1;
                  cascaded <= 1'b1;
                end
              end else begin
                lvl  <= LVL_SPURIOUS;
                SPUR <= 1'b1;
              end
            end
          end
        end
        ST_ACK1: begin
          if (rise) begin
            state <= ST_GAP;
            // A slave learns whether it is addressed only once the master drives CAS.
            if (role_q == ROLE_SLAVE && CAS_IN == ICW3[2:0]) begin
              match_q <= 1'b1;
              if (INT_REQ) begin
                lvl      <= IRQ_LVL;
                ISR_SET  <= 1'b1;
                set_done <= 1'b1;
                SPUR     <= 1'b0;
              end else begin
                lvl  <= LVL_SPURIOUS;
                SPUR <= 1'b1;
              end
            end
          end
        end
        ST_GAP: begin
          if (fall) begin
            state <= ST_ACK2;
            if (role_q == ROLE_MASTER) VEC_OE <= ~cascaded;
            else                       VEC_OE <= match_q;
          end
        end
        ST_ACK2: begin
          if (rise) begin
            state    <= ST_IDLE;
            VEC_OE   <= 1'b0;
            CAS_OE   <= 1'b0;
            CAS_OUT  <= 3'd0;
            SPUR     <= 1'b0;
            set_done <= 1'b0;
            if (aeoi_q && set_done) ISR_CLR <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inta_cascade_seq.sv
// Directed bench for the INTA cascade sequencer.
module tb_inta_cascade_seq;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       INTAn;
  logic       SPENn;
  logic       BUF;
  logic       MS;
  logic [7:0] ICW3;
  logic [4:0] VEC_BASE;
  logic       AEOI;
  logic       INT_REQ;
  logic [2:0] IRQ_LVL;
  logic [2:0] CAS_IN;
  logic [2:0] CAS_OUT;
  logic       CAS_OE;
  logic       VEC_OE;
  logic [7:0] VEC;
  logic       BUFENn;
  logic       ISR_SET;
  logic       ISR_CLR;
  logic [2:0] ISR_LVL;
  logic       SPUR;

  int checks   = 0;
  int failures = 0;

  inta_cascade_seq dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .INTAn    (INTAn),
    .SPENn    (SPENn),
    .BUF      (BUF),
    .MS       (MS),
    .ICW3     (ICW3),
    .VEC_BASE (VEC_BASE),
    .AEOI     (AEOI),
    .INT_REQ  (INT_REQ),
    .IRQ_LVL  (IRQ_LVL),
    .CAS_IN   (CAS_IN),
    .CAS_OUT  (CAS_OUT),
    .CAS_OE   (CAS_OE),
    .VEC_OE   (VEC_OE),
    .VEC      (VEC),
    .BUFENn   (BUFENn),
    .ISR_SET  (ISR_SET),
    .ISR_CLR  (ISR_CLR),
    .ISR_LVL  (ISR_LVL),
    .SPUR     (SPUR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RSTn = 1'b0; INTAn = 1'b1; SPENn = 1'b1; BUF = 1'b0; MS = 1'b0;
    ICW3 = 8'h00; VEC_BASE = 5'h08; AEOI = 1'b0; INT_REQ = 1'b0;
    IRQ_LVL = 3'd0; CAS_IN = 3'd0;
    #3;
    chk("rst_cas_oe",  8'(CAS_OE),  8'd0);
    chk("rst_vec_oe",  8'(VEC_OE),  8'd0);
    chk("rst_vec",     VEC,         8'h40);
    chk("rst_bufen",   8'(BUFENn),  8'd1);
    chk("rst_isr_set", 8'(ISR_SET), 8'd0);
    chk("rst_isr_lvl", 8'(ISR_LVL), 8'd0);
    chk("rst_spur",    8'(SPUR),    8'd0);
    step(); step();
    RSTn = 1'b1;
    step();

    // Master, cascaded slave on IR2
    ICW3 = 8'h04; INT_REQ = 1'b1; IRQ_LVL = 3'd2;
    INTAn = 1'b0; step();
    chk("m_casc_isr_set", 8'(ISR_SET), 8'd1);
    chk("m_casc_cas_oe",  8'(CAS_OE),  8'd1);
    chk("m_casc_cas_out", 8'(CAS_OUT), 8'd2);
    chk("m_casc_vec_oe1", 8'(VEC_OE),  8'd0);
    step();
    chk("m_casc_set_one", 8'(ISR_SET), 8'd0);
    chk("m_casc_hold_oe", 8'(CAS_OE),  8'd1);
    INTAn = 1'b1; step();
    chk("m_casc_gap_oe",  8'(CAS_OE),  8'd1);
    INTAn = 1'b0; step();
    chk("m_casc_ack2_oe", 8'(CAS_OE),  8'd1);
    chk("m_casc_vec_oe2", 8'(VEC_OE),  8'd0);
    INTAn = 1'b1; step();
    chk("m_casc_end_oe",  8'(CAS_OE),  8'd0);
    chk("m_casc_no_clr",  8'(ISR_CLR), 8'd0);
    step();

    // Master, non-cascaded, buffered, AEOI
    ICW3 = 8'h00; IRQ_LVL = 3'd5; AEOI = 1'b1; BUF = 1'b1; MS = 1'b1; SPENn = 1'b0;
    INTAn = 1'b0; step();
    chk("m_aeoi_isr_set", 8'(ISR_SET), 8'd1);
    chk("m_aeoi_cas_oe",  8'(CAS_OE),  8'd0);
    INTAn = 1'b1; step();
    INTAn = 1'b0; step();
    chk("m_aeoi_vec_oe",  8'(VEC_OE),  8'd1);
    chk("m_aeoi_vec",     VEC,         8'h45);
    chk("m_aeoi_bufen",   8'(BUFENn),  8'd0);
    INTAn = 1'b1; step();
    chk("m_aeoi_isr_clr", 8'(ISR_CLR), 8'd1);
    chk("m_aeoi_isr_lvl", 8'(ISR_LVL), 8'd5);
    chk("m_aeoi_set_clr", 8'(ISR_SET), 8'd0);
    chk("m_aeoi_vec_off", 8'(VEC_OE),  8'd0);
    step();
    chk("m_aeoi_clr_one", 8'(ISR_CLR), 8'd0);

    // Slave addressed (ID 3)
    BUF = 1'b0; MS = 1'b0; SPENn = 1'b0; AEOI = 1'b0;
    ICW3 = 8'h03; IRQ_LVL = 3'd1; CAS_IN = 3'd3;
    INTAn = 1'b0; step();
    chk("s_hit_no_set1",  8'(ISR_SET), 8'd0);
    chk("s_hit_cas_oe",   8'(CAS_OE),  8'd0);
    INTAn = 1'b1; step();
    chk("s_hit_isr_set",  8'(ISR_SET), 8'd1);
    chk("s_hit_isr_lvl",  8'(ISR_LVL), 8'd1);
    INTAn = 1'b0; step();
    chk("s_hit_vec_oe",   8'(VEC_OE),  8'd1);
    chk("s_hit_vec",      VEC,         8'h41);
    chk("s_hit_bufen",    8'(BUFENn),  8'd1);
    INTAn = 1'b1; step();
    chk("s_hit_vec_off",  8'(VEC_OE),  8'd0);
    step();

    // Slave not addressed
    CAS_IN = 3'd6; IRQ_LVL = 3'd4;
    INTAn = 1'b0; step();
    INTAn = 1'b1; step();
    chk("s_miss_isr_set", 8'(ISR_SET), 8'd0);
    INTAn = 1'b0; step();
    chk("s_miss_vec_oe",  8'(VEC_OE),  8'd0);
    INTAn = 1'b1; step();
    chk("s_miss_isr_clr", 8'(ISR_CLR), 8'd0);
    step();

    // Master spurious acknowledge
    SPENn = 1'b1; INT_REQ = 1'b0; ICW3 = 8'h80; AEOI = 1'b1; IRQ_LVL = 3'd3;
    INTAn = 1'b0; step();
    chk("spur_flag",      8'(SPUR),    8'd1);
    chk("spur_no_set",    8'(ISR_SET), 8'd0);
    chk("spur_cas_oe",    8'(CAS_OE),  8'd0);
    chk("spur_lvl",       8'(ISR_LVL), 8'd7);
    INTAn = 1'b1; step();
    INTAn = 1'b0; step();
    chk("spur_vec_oe",    8'(VEC_OE),  8'd1);
    chk("spur_vec",       VEC,         8'h47);
    INTAn = 1'b1; step();
    chk("spur_clear",     8'(SPUR),    8'd0);
    chk("spur_no_clr",    8'(ISR_CLR), 8'd0);
    step();

    // Reset in GAP while driving CAS
    ICW3 = 8'h04; INT_REQ = 1'b1; IRQ_LVL = 3'd2; AEOI = 1'b1;
    INTAn = 1'b0; step();
    INTAn = 1'b1; step();
    chk("rgap_cas_oe_pre", 8'(CAS_OE), 8'd1);
    #2 RSTn = 1'b0;
    #1;
    chk("rgap_cas_oe_rst", 8'(CAS_OE), 8'd0);
    step();
    RSTn = 1'b1;
    step();
    chk("rgap_no_clr",     8'(ISR_CLR), 8'd0);
    INTAn = 1'b0; step();
    chk("rgap_isr_set",    8'(ISR_SET), 8'd1);
    chk("rgap_cas_out",    8'(CAS_OUT), 8'd2);
    INTAn = 1'b1; step();
    INTAn = 1'b0; step();
    INTAn = 1'b1; step();
    chk("rgap_end_oe",     8'(CAS_OE),  8'd0);
    chk("rgap_end_clr",    8'(ISR_CLR), 8'd1);
    step();

    // Role strap changes mid-sequence
    SPENn = 1'b0; AEOI = 1'b0; ICW3 = 8'h05; CAS_IN = 3'd5; IRQ_LVL = 3'd3;
    INTAn = 1'b0; step();
    chk("role_no_set1",   8'(ISR_SET), 8'd0);
    INTAn = 1'b1; step();
    chk("role_isr_set",   8'(ISR_SET), 8'd1);
    SPENn = 1'b1;
    INTAn = 1'b0; step();
    chk("role_vec_oe",    8'(VEC_OE),  8'd1);
    chk("role_vec",       VEC,         8'h43);
    chk("role_cas_oe",    8'(CAS_OE),  8'd0);
    INTAn = 1'b1; step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/inta_cascade_seq.md
INTA_CASCADE_SEQ -- requirements
Module: inta_cascade_seq

Interface
REQ-001 CLK  in  1  system clock; all state changes on rising edge.
REQ-002 RSTn  in  1  reset, asynchronous, active-low.
REQ-003 INTAn  in  1  CPU interrupt acknowledge, active-low, already synchronous to CLK.
REQ-004 SPENn  in  1  master/slave strap in non-buffered mode: 1=master, 0=slave.
REQ-005 BUF  in  1  buffered mode; when 1, MS selects the role and SPENn is ignored.
REQ-006 MS  in  1  role in buffered mode: 1=master, 0=slave.
REQ-007 ICW3  in  8  master: bit n=1 means a slave sits on IRn; slave: [2:0] is its own ID.
REQ-008 VEC_BASE  in  5  ICW2 T7..T3.
REQ-009 AEOI  in  1  automatic end-of-interrupt enable.
REQ-010 INT_REQ  in  1  priority resolver has a pending unmasked request.
REQ-011 IRQ_LVL  in  3  highest-priority pending level.
REQ-012 CAS_IN  in  3  cascade bus sampled value.
REQ-013 CAS_OUT  out  3  cascade ID driven by the master.
REQ-014 CAS_OE  out  1  cascade output enable; the top level drives CAS only when this is 1.
REQ-015 VEC_OE  out  1  drive VEC onto the data bus.
REQ-016 VEC  out  8  {VEC_BASE, latched level}.
REQ-017 BUFENn  out  1  external transceiver enable, active-low.
REQ-018 ISR_SET  out  1  one-cycle pulse that sets the ISR bit ISR_LVL.
REQ-019 ISR_CLR  out  1  one-cycle pulse that clears the ISR bit ISR_LVL (AEOI).
REQ-020 ISR_LVL  out  3  latched serviced level.
REQ-021 SPUR  out  1  the current acknowledge is spurious (IR7 default).

Function
REQ-022 Edge detection: fall is INTAn=0 with previous sample 1; rise is INTAn=1 with previous sample 0. Outputs are registered and change on the detecting edge.
REQ-023 FSM states: IDLE, ACK1, GAP, ACK2.
- IDLE->ACK1 on fall.
- ACK1->GAP on rise.
- GAP->ACK2 on fall.
- ACK2->IDLE on rise.
- Other edges are ignored.
REQ-024 On IDLE->ACK1, the role and AEOI are snapshotted; config changes mid-sequence have no effect until IDLE.
REQ-025 On IDLE->ACK1, master path:
- INT_REQ=1: latch lvl=IRQ_LVL and pulse ISR_SET.
- INT_REQ=0: lvl=7, SPUR=1, no ISR_SET.
REQ-026 Master cascade: if SPUR=0 and ICW3[lvl]=1:
- On the same edge: CAS_OUT=lvl, CAS_OE=1.
- CAS_OE is held until ACK2->IDLE.
- VEC_OE stays 0 for the whole sequence.
REQ-027 Master non-cascaded or spurious: CAS_OE=0; VEC_OE=1 throughout ACK2.
REQ-028 Slave: on ACK1->GAP, sample CAS_IN; match = (CAS_IN==ICW3[2:0]).
- Match: latch lvl=IRQ_LVL, pulse ISR_SET, VEC_OE=1 throughout ACK2.
- INT_REQ=0 on match: lvl=7, SPUR=1, no ISR_SET.
REQ-029 Slave no-match: the FSM still walks all states; VEC_OE, ISR_SET and ISR_CLR remain 0.
REQ-030 A slave never asserts CAS_OE.
REQ-031 AEOI: on ACK2->IDLE, pulse ISR_CLR with ISR_LVL=lvl, only if ISR_SET fired in this sequence.
REQ-032 VEC = {VEC_BASE, lvl}, valid whenever VEC_OE=1.
REQ-033 BUFENn = ~(BUF & VEC_OE) when the role is slave; in master buffered mode, BUFENn = ~VEC_OE.
REQ-034 SPUR clears on ACK2->IDLE.
REQ-035 ISR_SET and ISR_CLR are never high in the same cycle.
REQ-036 A fall in IDLE with INTAn held low is a single acknowledge; ACK1 holds until rise.

Reset
REQ-037 RSTn=0 immediately forces:
- state IDLE;
- CAS_OUT=0, CAS_OE=0, VEC_OE=0, VEC={VEC_BASE,3'b000};
- BUFENn=1, ISR_SET=0, ISR_CLR=0, ISR_LVL=0, SPUR=0;
- previous INTAn sample = 1.
REQ-038 Reset mid-sequence aborts it: no ISR_CLR, bus outputs released; a low INTAn after reset needs a fresh fall.

Structure
REQ-039 Shared package pic_pkg holds:
- state encoding (2-bit);
- role constants ROLE_MASTER and ROLE_SLAVE;
- LVL_SPURIOUS=3'd7.
REQ-040 One sub-module, inta_edge_det, produces fall and rise; everything else sits in inta_cascade_seq.

Verification
REQ-041 Master, ICW3=8'h04, INT_REQ=1, IRQ_LVL=2, two INTA pulses -> ISR_SET 1 cycle at the first fall, CAS_OUT=2 and CAS_OE=1 until the second rise, VEC_OE never 1.
REQ-042 Master, ICW3=0, VEC_BASE=5'h08, IRQ_LVL=5, AEOI=1 -> VEC_OE=1 during the second low with VEC=8'h45; ISR_CLR pulse with ISR_LVL=5 at the second rise.
REQ-043 Slave, ICW3[2:0]=3, CAS_IN=3 at the first rise, IRQ_LVL=1 -> ISR_SET at the first rise, VEC_OE during ACK2; repeat with CAS_IN=6 -> no ISR_SET and no VEC_OE.
REQ-044 Master, INT_REQ=0 at the first fall, ICW3=8'h80 -> SPUR=1, no ISR_SET, CAS_OE=0, VEC=VEC_BASE:7 during ACK2.
REQ-045 RSTn pulled low in GAP with CAS_OE=1 -> CAS_OE=0 immediately; the next INTA sequence starts from IDLE normally.
REQ-046 Toggle SPENn during GAP -> the role is unchanged for the current sequence.
